// File: rtl/icb_pkg.sv
// Shared ICB types: arbiter state encoding, default bus widths and the command bundle
// used by the register bank, the motion sequencer and the arbiter.
package icb_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } icb_state_e;

    typedef struct packed {
        logic [ICB_AW-1:0] addr;
        logic              read;
        logic [ICB_DW-1:0] wdata;
    } icb_cmd_t;

endpackage

// File: rtl/icb_arbiter_2to1_rr.sv
// Two-input round-robin picker, purely combinational; the pointer lives in the parent.
// On a tie the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       vld_o,
    output logic       gnt_o
);

    always_comb begin
        vld_o = |req_i;
        gnt_o = 1'b0;
        if (req_i == 2'b11) begin
            gnt_o = ~last_i;
        end else if (req_i[1]) begin
            gnt_o = 1'b1;
        end
    end

endmodule

// File: rtl/icb_arbiter_2to1.sv
// Two-master to one-slave ICB arbiter, one outstanding transaction, round-robin grant locked
// from command presentation to response handshake; cmd and rsp paths are combinational.
module icb_arbiter_2to1
    import icb_pkg::*;
#(
    parameter int AW = ICB_AW,
    parameter int DW = ICB_DW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_icb_cmd_valid,
    output logic          m0_icb_cmd_ready,
    input  logic [AW-1:0] m0_icb_cmd_addr,
    input  logic          m0_icb_cmd_read,
    input  logic [DW-1:0] m0_icb_cmd_wdata,
    output logic          m0_icb_rsp_valid,
    input  logic          m0_icb_rsp_ready,
    output logic [DW-1:0] m0_icb_rsp_rdata,

    input  logic          m1_icb_cmd_valid,
    output logic          m1_icb_cmd_ready,
    input  logic [AW-1:0] m1_icb_cmd_addr,
    input  logic          m1_icb_cmd_read,
    input  logic [DW-1:0] m1_icb_cmd_wdata,
    output logic          m1_icb_rsp_valid,
    input  logic          m1_icb_rsp_ready,
    output logic [DW-1:0] m1_icb_rsp_rdata,

    output logic          s_icb_cmd_valid,
    input  logic          s_icb_cmd_ready,
    output logic [AW-1:0] s_icb_cmd_addr,
    output logic          s_icb_cmd_read,
    output logic [DW-1:0] s_icb_cmd_wdata,
    input  logic          s_icb_rsp_valid,
    output logic          s_icb_rsp_ready,
    input  logic [DW-1:0] s_icb_rsp_rdata,

    output logic          busy,
    output logic          stale_rsp
);

    icb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    logic [1:0] req;
    logic [1:0] rsp_rdy;
    logic [1:0] cmd_rdy;
    logic [1:0] rsp_vld;
    logic       arb_vld;
    logic       arb_gnt;
    logic       win;
    logic       fwd;
    logic       s_cmd_vld;
    logic       s_rsp_rdy;
    logic       cmd_hs;
    logic       rsp_hs;
    logic       stale;

    assign req     = {m1_icb_cmd_valid, m0_icb_cmd_valid};
    assign rsp_rdy = {m1_icb_rsp_ready, m0_icb_rsp_ready};

    rr_arb2 u_rr_arb2 (
        .req_i  (req),
        .last_i (last_q),
        .vld_o  (arb_vld),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        win       = owner_q;
        fwd       = 1'b0;
        s_cmd_vld = 1'b0;
        cmd_rdy   = 2'b00;
        rsp_vld   = 2'b00;
        s_rsp_rdy = 1'b0;
        stale     = 1'b0;
        cmd_hs    = 1'b0;
        rsp_hs    = 1'b0;

        case (state_q)
            IDLE: begin
                win       = arb_gnt;
                fwd       = arb_vld;
                s_cmd_vld = arb_vld;
            end
            CMD: begin
                // Grant is locked to the owner; a late request from the other master waits.
                fwd       = 1'b1;
                s_cmd_vld = req[owner_q];
            end
            default: ;
        endcase

        cmd_hs = s_cmd_vld && s_icb_cmd_ready;
        if (fwd) begin
            cmd_rdy[win] = s_icb_cmd_ready;
        end

        if (state_q == RSP) begin
            rsp_vld[owner_q] = s_icb_rsp_valid;
            s_rsp_rdy        = rsp_rdy[owner_q];
            if (s_icb_rsp_valid && rsp_rdy[owner_q]) begin
                state_d = IDLE;
            end
        end else if (cmd_hs) begin
            // A slave may answer in the command cycle; route that response to the winner.
            rsp_vld[win] = s_icb_rsp_valid;
            s_rsp_rdy    = rsp_rdy[win];
            rsp_hs       = s_icb_rsp_valid && rsp_rdy[win];
            last_d       = win;
            if (rsp_hs) begin
                state_d = IDLE;
            end else begin
                state_d = RSP;
                owner_d = win;
            end
        end else if (state_q == IDLE) begin
            // Nobody owns the response channel: drain leftovers so the slave cannot wedge.
            s_rsp_rdy = 1'b1;
            stale     = s_icb_rsp_valid;
            if (arb_vld) begin
                state_d = CMD;
                owner_d = arb_gnt;
            end
        end

        if (rst) begin
            s_cmd_vld = 1'b0;
            cmd_rdy   = 2'b00;
            rsp_vld   = 2'b00;
            s_rsp_rdy = 1'b1;
            stale     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign s_icb_cmd_valid  = s_cmd_vld;
    assign s_icb_cmd_addr   = win ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read   = win ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata  = win ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_rsp_ready  = s_rsp_rdy;

    assign m0_icb_cmd_ready = cmd_rdy[0];
    assign m1_icb_cmd_ready = cmd_rdy[1];
    assign m0_icb_rsp_valid = rsp_vld[0];
    assign m1_icb_rsp_valid = rsp_vld[1];
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

    assign busy      = (state_q != IDLE);
    assign stale_rsp = stale;

endmodule
